// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared state encoding and default sizing for the clock
//               ratio meter.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_def_cnt_w    = 8;
    localparam int c_def_lock_cnt = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_acq    = 2'd1;
    localparam state_t c_st_locked = 2'd2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/rise_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge_det
// Description : Registers sig_in once and flags its low-to-high transition.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic r_sig_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_prev <= 1'b0;
        end else begin
            r_sig_prev <= sig_in;
        end
    end

    assign rise = sig_in & ~r_sig_prev;

endmodule : rise_edge_det
`default_nettype wire

// File: rtl/clk_ratio_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_ratio_meter
// Description : Measures period and high time of sig_in in clk cycles and
//               declares lock after LOCK_CNT consecutive equal periods.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_ratio_meter
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = c_def_cnt_w,
    parameter int LOCK_CNT = c_def_lock_cnt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic             ratio_valid,
    output logic             locked,
    output logic             err
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_max  = '1;
    localparam logic [MW-1:0]    c_lock = MW'(LOCK_CNT);

    logic             w_rise;
    logic             w_sat;
    logic             w_same;
    logic [MW-1:0]    w_match_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_acc;
    logic [MW-1:0]    r_match_cnt;

    rise_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (w_rise)
    );

    assign w_sat       = (r_period_cnt == c_max);
    assign w_same      = (r_period_cnt == ratio);
    assign w_match_inc = r_match_cnt + 1'b1;

    // Counters value at an edge cycle is the measurement for the period just ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_high_acc   <= '0;
        end else if (w_rise) begin
            r_period_cnt <= CNT_W'(1);
            r_high_acc   <= CNT_W'(1);
        end else begin
            if (!w_sat) begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
            if (sig_in && (r_high_acc != c_max)) begin
                r_high_acc <= r_high_acc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_match_cnt <= '0;
            ratio       <= '0;
            high_cnt    <= '0;
            ratio_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            ratio_valid <= 1'b0;
            err         <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_rise) begin
                        r_state     <= c_st_acq;
                        r_match_cnt <= '0;
                    end
                end
                c_st_acq: begin
                    if (w_rise) begin
                        ratio       <= r_period_cnt;
                        high_cnt    <= r_high_acc;
                        ratio_valid <= 1'b1;
                        if (w_same && (r_match_cnt != '0)) begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == c_lock) begin
                                r_state <= c_st_locked;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_match_cnt <= MW'(1);
                        end
                    end else if (w_sat) begin
                        err         <= 1'b1;
                        r_state     <= c_st_idle;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                    end
                end
                c_st_locked: begin
                    if (w_rise) begin
                        ratio       <= r_period_cnt;
                        high_cnt    <= r_high_acc;
                        ratio_valid <= 1'b1;
                        if (!w_same) begin
                            err         <= 1'b1;
                            r_state     <= c_st_acq;
                            r_match_cnt <= MW'(1);
                            locked      <= 1'b0;
                        end
                    end else if (w_sat) begin
                        err         <= 1'b1;
                        r_state     <= c_st_idle;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_match_cnt <= '0;
                    locked      <= 1'b0;
                end
            endcase
        end
    end

endmodule : clk_ratio_meter
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_ratio_meter
// Description : Directed self-checking bench for clk_ratio_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_meter;

    logic       clk;
    logic       rst;
    logic       sig_in;
    logic [7:0] ratio;
    logic [7:0] high_cnt;
    logic       ratio_valid;
    logic       locked;
    logic       err;

    int n_vec;
    int n_fail;
    int err_seen;
    int valid_seen;
    int err_at;

    clk_ratio_meter #(
        .CNT_W    (8),
        .LOCK_CNT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .ratio       (ratio),
        .high_cnt    (high_cnt),
        .ratio_valid (ratio_valid),
        .locked      (locked),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input int v, input int r, input int h,
                        input int l, input int e);
        check({tag, ".valid"},  {31'd0, ratio_valid}, v);
        check({tag, ".ratio"},  {24'd0, ratio},       r);
        check({tag, ".high"},   {24'd0, high_cnt},    h);
        check({tag, ".locked"}, {31'd0, locked},      l);
        check({tag, ".err"},    {31'd0, err},         e);
    endtask

    // One clk cycle with sig_in = v; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
        if (err === 1'b1) err_seen++;
        if (ratio_valid === 1'b1) valid_seen++;
    endtask

    task automatic edge_step();
        drive(1'b1);
    endtask

    // Remainder of a period of n cycles whose first h cycles are high.
    task automatic rest(input int n, input int h);
        for (int i = 1; i < n; i++) drive(i < h);
    endtask

    initial begin
        n_vec = 0; n_fail = 0; err_seen = 0; valid_seen = 0; err_at = -1;
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk5("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Divide-by-3, pattern 0,0,1
        drive(1'b0); drive(1'b0);
        edge_step(); chk5("d3.arm", 0, 0, 0, 0, 0); rest(3, 1);
        edge_step(); chk5("d3.e2", 1, 3, 1, 0, 0);
        drive(1'b0); check("d3.e2.pulse_end", {31'd0, ratio_valid}, 0);
        drive(1'b0);
        edge_step(); chk5("d3.e3", 1, 3, 1, 0, 0); rest(3, 1);
        edge_step(); chk5("d3.e4", 1, 3, 1, 0, 0); rest(3, 1);
        edge_step(); chk5("d3.e5", 1, 3, 1, 1, 0); rest(4, 1);

        // One period of 4 breaks lock, then four periods of 3 relock
        edge_step(); chk5("brk.p4", 1, 4, 1, 0, 1);
        drive(1'b0); check("brk.err_end", {31'd0, err}, 0);
        rest(2, 0);
        edge_step(); chk5("rl.p1", 1, 3, 1, 0, 0); rest(3, 1);
        edge_step(); chk5("rl.p2", 1, 3, 1, 0, 0); rest(3, 1);
        edge_step(); chk5("rl.p3", 1, 3, 1, 0, 0); rest(3, 1);
        edge_step(); chk5("rl.p4", 1, 3, 1, 1, 0);

        // sig_in stuck low for 300 cycles while locked
        err_seen = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0);
            if (err === 1'b1) err_at = i;
        end
        check("to.err_count", err_seen, 1);
        check("to.err_cycle", err_at, 254);
        check("to.locked", {31'd0, locked}, 0);
        check("to.ratio_held", {24'd0, ratio}, 3);
        check("to.high_held", {24'd0, high_cnt}, 1);
        edge_step(); chk5("to.rearm", 0, 3, 1, 0, 0); rest(8, 4);

        // Divide-by-8, 50% duty
        err_seen = 0; valid_seen = 0;
        for (int p = 1; p <= 6; p++) begin
            edge_step();
            check("d8.valid", {31'd0, ratio_valid}, 1);
            check("d8.ratio", {24'd0, ratio}, 8);
            check("d8.high", {24'd0, high_cnt}, 4);
            check("d8.locked", {31'd0, locked}, (p >= 4) ? 1 : 0);
            rest(8, 4);
        end
        check("d8.valid_count", valid_seen, 6);
        check("d8.err_count", err_seen, 0);

        // Asynchronous reset mid-period while locked
        edge_step(); drive(1'b1); drive(1'b1); drive(1'b1);
        rst = 1'b1;
        #1;
        chk5("arst", 0, 0, 0, 0, 0);
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0);
        edge_step(); chk5("arst.arm", 0, 0, 0, 0, 0); rest(8, 4);
        edge_step(); chk5("arst.p8", 1, 8, 4, 0, 0); rest(255, 1);

        // Period of exactly 255: edge coincides with saturation
        err_seen = 0;
        edge_step(); chk5("p255", 1, 255, 1, 0, 0);
        check("p255.err_count", err_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_clk_ratio_meter
`default_nettype wire

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters and the measured outputs.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive equal periods required before lock.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  1  divided-clock or strobe waveform to measure; synchronous to clk.
REQ-006 ratio  output  CNT_W  last measured period, in clk cycles.
REQ-007 high_cnt  output  CNT_W  clk cycles sig_in was high during the last measured period.
REQ-008 ratio_valid  output  1  one-cycle pulse when ratio and high_cnt update.
REQ-009 locked  output  1  level; LOCK_CNT consecutive equal periods have been seen.
REQ-010 err  output  1  one-cycle pulse on loss of lock or timeout.

Function
REQ-011 Rising edge detection shall be edge = sig_in & ~sig_prev, where sig_prev is sig_in registered once.
REQ-012 The period counter shall load 1 on an edge cycle and otherwise increment, saturating at 2^CNT_W-1.
REQ-013 The high counter shall load 1 on an edge cycle and otherwise increment while sig_in=1, saturating likewise.
REQ-014 Period definition:
- For edges at cycles t1 and t2, the measured period is t2-t1, which equals the period counter value at t2.
- The measured high time is the high counter value at t2.
REQ-015 The first edge after reset or after a timeout shall only arm measurement; it shall not produce ratio_valid.
REQ-016 On each subsequent edge:
- ratio and high_cnt shall take the measured values.
- ratio_valid shall pulse in the cycle after the edge cycle.
REQ-017 The state machine shall have three states: IDLE (no edge yet), ACQ (measuring), LOCKED.
REQ-018 Transitions out of IDLE and within ACQ:
- IDLE: first edge -> ACQ, match_cnt=0.
- ACQ, measured period equals current ratio and match_cnt>0: increment match_cnt.
- ACQ, any other measurement: match_cnt=1.
- ACQ: match_cnt reaching LOCK_CNT -> LOCKED.
REQ-019 LOCKED behaviour:
- A measured period equal to ratio keeps LOCKED.
- An unequal period shall pulse err, go to ACQ with match_cnt=1, and still update ratio.
REQ-020 Timeout:
- Triggered when the period counter reaches saturation in any state except IDLE.
- Shall pulse err once, go to IDLE, and deassert locked.
- ratio and high_cnt shall hold their values.
REQ-021 locked shall be registered and equal 1 exactly while in LOCKED.
REQ-022 If an edge coincides with counter saturation, the edge shall win: the measurement is taken and no timeout occurs.
REQ-023 A constant sig_in (0 or 1) shall produce no edges and hence a timeout after 2^CNT_W-1 cycles.

Reset
REQ-024 Asserting rst shall asynchronously force the following, regardless of current state:
- state=IDLE
- ratio=0, high_cnt=0
- ratio_valid=0, locked=0, err=0
- both counters=0, match_cnt=0, sig_prev=0
REQ-025 After rst deasserts, the first sampled edge shall be treated per REQ-015.

Structure
REQ-026 The state encoding and the default CNT_W and LOCK_CNT values shall reside in the shared package clk_div_pkg.
REQ-027 Edge detection shall be the sub-module rise_edge_det (sig_prev register plus edge output).
REQ-028 All outputs shall be registered; there shall be no combinational path from sig_in to any output.

Verification
REQ-029 Divide-by-3 (pattern 0,0,1 repeating) -> ratio=3, high_cnt=1, locked=1 the cycle after the 5th rising edge.
REQ-030 Divide-by-8 (50% duty) -> ratio=8, high_cnt=4, ratio_valid pulses every 8 cycles, err never pulses.
REQ-031 Locked at ratio 3, then one period of 4 -> err pulse, locked=0, ratio=4; relock after 4 further equal periods.
REQ-032 sig_in held at 0 for 300 cycles while locked (CNT_W=8) -> single err pulse, locked=0, state IDLE, ratio held.
REQ-033 rst asserted mid-period while locked -> all outputs 0 immediately; after release, first edge gives no ratio_valid.
REQ-034 Period of exactly 255 with CNT_W=8 -> edge coincides with saturation, ratio=255, no err.
